sbp_update_scheduler: RTL
=========================

SBP_UPDATE_SCHEDULER -- requirements
Module: sbp_update_scheduler

Interface
REQ-001 SHALL have parameter STAGE_ID_BITS, default 6, width of stage-id fields.
REQ-002 SHALL have parameter LOCATION_BITS, default 11, width of location fields.
REQ-003 SHALL have parameter DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 update commands.
REQ-004 SHALL have parameter STARVE_LIMIT, default 64, blocked cycles before lookup hold is raised.
REQ-005 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset (asserted when 0)
- cmd_valid_i  in  1  control-plane update command valid
- cmd_ready_o  out  1  FIFO can accept command
- cmd_stage_id_i  in  STAGE_ID_BITS  target entry stage
- cmd_location_i  in  LOCATION_BITS  target entry location
- cmd_ip_addr_i  in  32  prefix to write
- cmd_length_i  in  6  prefix length, 0..32
- cmd_childs_stage_id_i  in  STAGE_ID_BITS  child pointer stage
- cmd_childs_location_i  in  LOCATION_BITS  child pointer location
- cmd_childs_lr_i  in  2  child left/right presence
- lookup_i  in  1  lookup injected into pipeline this cycle (same signal the lookup pipeline sees)
- upd_o  out  1  update offered to lookup pipeline
- upd_stage_id_o, upd_location_o, upd_ip_addr_o, upd_length_o, upd_childs_stage_id_o, upd_childs_location_o, upd_childs_lr_o  out  as cmd_*  head command fields
- lookup_hold_o  out  1  request upstream to suppress lookups
- level_o  out  DEPTH_LOG2+1  commands held, including head register
- drop_o  out  1  one-cycle pulse: command rejected (length > 32)

Function
REQ-006 SHALL accept a command on a rising edge where cmd_valid_i && cmd_ready_o; cmd_ready_o = level_o < 2**DEPTH_LOG2, registered.
REQ-007 SHALL reject an accepted command with cmd_length_i > 32: no enqueue, drop_o = 1 next cycle, level unchanged.
REQ-008 SHALL drive all upd_* outputs from a head register; fields stable while upd_o = 1 until consumed.
REQ-009 SHALL consume the head on an edge where upd_o && !lookup_i (lookups have priority); upd_o never masked combinationally by lookup_i.
REQ-010 SHALL refill the head the cycle after consumption from the FIFO if non-empty (upd_o stays 1, back-to-back updates at one per cycle), else deassert upd_o.
REQ-011 SHALL bypass an empty FIFO: a command accepted with no head valid appears on upd_o one cycle after acceptance.
REQ-012 SHALL issue commands strictly in acceptance order.
REQ-013 SHALL handle simultaneous accept and consume with level unchanged and no loss; at full, accept is blocked even if a consume occurs that cycle.
REQ-014 SHALL implement a 3-state machine: IDLE (no head), OFFER (head valid, starve counter counting blocked cycles), HOLD (lookup_hold_o = 1).
REQ-015 SHALL transition IDLE->OFFER on head load; OFFER->HOLD when counter reaches STARVE_LIMIT-1 while lookup_i = 1; OFFER/HOLD->IDLE on consume with empty FIFO; HOLD->OFFER on consume with non-empty FIFO; counter clears on every consume.
REQ-016 SHALL register lookup_hold_o (asserted from the cycle after entering HOLD, deasserted the cycle after consume); the block never forces consumption while lookup_i = 1.
REQ-017 SHALL saturate the starve counter at STARVE_LIMIT-1.

Reset
REQ-018 SHALL, while rst = 0 at a rising edge, clear FIFO pointers, head valid, counter; state IDLE; upd_o = 0, lookup_hold_o = 0, drop_o = 0, level_o = 0, cmd_ready_o = 0; upd_* field outputs = 0.
REQ-019 SHALL assert cmd_ready_o the first cycle after rst returns to 1; reset mid-operation discards all queued commands without issuing them.

Structure
REQ-020 SHALL place the update command struct (all cmd fields), the state enum and default widths in shared package sbp_pkg.
REQ-021 SHALL use one sub-module, sbp_fifo (synchronous FIFO, show-ahead, parameterised width/depth), for command storage.

Verification
REQ-022 Reset: hold rst = 0 for 3 cycles with cmd_valid_i = 1 -> cmd_ready_o = 0, upd_o = 0, level_o = 0; first ready the cycle after release.
REQ-023 Bypass: empty, lookup_i = 0, push {stage 3, loc 0x12, ip 0x0A000000, len 8} -> upd_o = 1 with those fields next cycle, consumed one cycle later, level_o back to 0.
REQ-024 Priority: head valid, lookup_i = 1 for 10 cycles -> upd_o and fields stable 10 cycles, consume on first cycle lookup_i = 0.
REQ-025 Starvation: lookup_i = 1 continuously, STARVE_LIMIT = 64 -> lookup_hold_o rises after 64 blocked cycles; drop lookup_i -> consume, hold falls next cycle.
REQ-026 Full/order: push 17 commands with lookup_i = 1 (DEPTH_LOG2 = 4) -> cmd_ready_o = 0 at level 16; then lookup_i = 0 -> 16 updates back-to-back in push order.
REQ-027 Drop: push cmd_length_i = 33 -> drop_o pulse one cycle, level_o unchanged, no upd_o.

Source files
------------

// File: rtl/sbp_pkg.sv
// sbp_pkg: shared widths, update command record and scheduler state encoding
package sbp_pkg;
  localparam int SBP_STAGE_ID_BITS = 6;
  localparam int SBP_LOCATION_BITS = 11;
  localparam int SBP_DEPTH_LOG2 = 4;
  localparam int SBP_STARVE_LIMIT = 64;
  typedef enum logic [1:0] {IDLE, OFFER, HOLD} sbp_state_e;
  typedef struct packed {
    logic [SBP_STAGE_ID_BITS-1:0] stage_id;
    logic [SBP_LOCATION_BITS-1:0] location;
    logic [31:0] ip_addr;
    logic [5:0] length;
    logic [SBP_STAGE_ID_BITS-1:0] childs_stage_id;
    logic [SBP_LOCATION_BITS-1:0] childs_location;
    logic [1:0] childs_lr;
  } sbp_cmd_t;
endpackage

// File: rtl/sbp_fifo.sv
// sbp_fifo: synchronous show-ahead FIFO, active-low synchronous reset
module sbp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
  assign dout = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr == {~rd_ptr[DEPTH_LOG2], rd_ptr[DEPTH_LOG2-1:0]};
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/sbp_update_scheduler.sv
// sbp_update_scheduler: queues control-plane entry updates and slips them into
// lookup-free pipeline cycles, raising lookup_hold_o if lookups starve them.
module sbp_update_scheduler
  import sbp_pkg::*;
#(
  parameter int STAGE_ID_BITS = SBP_STAGE_ID_BITS,
  parameter int LOCATION_BITS = SBP_LOCATION_BITS,
  parameter int DEPTH_LOG2 = SBP_DEPTH_LOG2,
  parameter int STARVE_LIMIT = SBP_STARVE_LIMIT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [STAGE_ID_BITS-1:0] cmd_stage_id_i,
  input  logic [LOCATION_BITS-1:0] cmd_location_i,
  input  logic [31:0]              cmd_ip_addr_i,
  input  logic [5:0]               cmd_length_i,
  input  logic [STAGE_ID_BITS-1:0] cmd_childs_stage_id_i,
  input  logic [LOCATION_BITS-1:0] cmd_childs_location_i,
  input  logic [1:0]               cmd_childs_lr_i,
  input  logic                     lookup_i,
  output logic                     upd_o,
  output logic [STAGE_ID_BITS-1:0] upd_stage_id_o,
  output logic [LOCATION_BITS-1:0] upd_location_o,
  output logic [31:0]              upd_ip_addr_o,
  output logic [5:0]               upd_length_o,
  output logic [STAGE_ID_BITS-1:0] upd_childs_stage_id_o,
  output logic [LOCATION_BITS-1:0] upd_childs_location_o,
  output logic [1:0]               upd_childs_lr_o,
  output logic                     lookup_hold_o,
  output logic [DEPTH_LOG2:0]      level_o,
  output logic                     drop_o
);
  localparam int W = 2 * STAGE_ID_BITS + 2 * LOCATION_BITS + 40;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT - 1);
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(2 ** DEPTH_LOG2);
  logic [W-1:0] cmd, head, fifo_q;
  logic head_valid, fifo_empty, fifo_full, accept, consume, head_free, load, push, pop;
  logic [DEPTH_LOG2:0] level_next;
  logic [CW-1:0] cnt;
  sbp_state_e state;
  assign cmd = {cmd_stage_id_i, cmd_location_i, cmd_ip_addr_i, cmd_length_i,
                cmd_childs_stage_id_i, cmd_childs_location_i, cmd_childs_lr_i};
  assign {upd_stage_id_o, upd_location_o, upd_ip_addr_o, upd_length_o,
          upd_childs_stage_id_o, upd_childs_location_o, upd_childs_lr_o} = head;
  assign upd_o = head_valid;
  always_comb begin
    accept = cmd_valid_i && cmd_ready_o && cmd_length_i <= 6'd32;
    consume = head_valid && !lookup_i;
    head_free = !head_valid || consume;
    load = head_free && (!fifo_empty || accept);
    pop = head_free && !fifo_empty;
    push = accept && !fifo_full && !(head_free && fifo_empty);
    level_next = level_o + (DEPTH_LOG2 + 1)'(accept) - (DEPTH_LOG2 + 1)'(consume);
  end
  sbp_fifo #(.WIDTH(W), .DEPTH_LOG2(DEPTH_LOG2)) fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(cmd),
    .dout(fifo_q), .empty(fifo_empty), .full(fifo_full)
  );
  // An empty FIFO is bypassed so a lone command reaches the head in one cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      head <= '0;
      head_valid <= 1'b0;
      level_o <= '0;
      cmd_ready_o <= 1'b0;
      drop_o <= 1'b0;
    end else begin
      if (load) head <= fifo_empty ? cmd : fifo_q;
      head_valid <= load || !head_free;
      level_o <= level_next;
      cmd_ready_o <= level_next < LEVEL_FULL;
      drop_o <= cmd_valid_i && cmd_ready_o && cmd_length_i > 6'd32;
    end
  end
  // In OFFER every non-consume cycle is a blocked one, so cnt counts them
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      lookup_hold_o <= 1'b0;
    end else if (consume) begin
      state <= load ? OFFER : IDLE;
      cnt <= '0;
      lookup_hold_o <= 1'b0;
    end else if (state == IDLE) begin
      state <= load ? OFFER : IDLE;
    end else if (state == OFFER && cnt == STARVE_MAX) begin
      state <= HOLD;
      lookup_hold_o <= 1'b1;
    end else if (state == OFFER) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule
